// File: rtl/matrix_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_ctrl_pkg
// Summary  : Shared state encoding, matrix geometry and row helpers for the
//            7x5 matrix frame scheduler.
// Revision : 1.0
// ============================================================================
package matrix_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW0 = 2'd1,
    SHOW1 = 2'd2,
    BLANK = 2'd3
  } state_e;

  localparam int NUM_ROWS   = 7;
  localparam int NUM_COLS   = 5;
  localparam int FRAME_BITS = NUM_ROWS * NUM_COLS;

  localparam logic [NUM_ROWS-1:0] ROW_FIRST = NUM_ROWS'(1);

  function automatic logic [NUM_ROWS-1:0] rotl_row(input logic [NUM_ROWS-1:0] r);
    return {r[NUM_ROWS-2:0], r[NUM_ROWS-1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/row_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : row_scan_counter
// Summary  : ROW_TICKS prescaler driving a one-hot row rotator; restart_i
//            returns the strobe to row 0 with a fresh prescale period.
// Revision : 1.0
// ============================================================================
module row_scan_counter
  import matrix_ctrl_pkg::*;
#(
  parameter int ROW_TICKS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                restart_i,
  input  logic                advance_i,
  output logic [NUM_ROWS-1:0] row_o
);

  localparam int PW = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(ROW_TICKS - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [NUM_ROWS-1:0] row_q, row_d;

  always_comb begin
    presc_d = presc_q;
    row_d   = row_q;
    if (restart_i) begin
      presc_d = '0;
      row_d   = ROW_FIRST;
    end else if (advance_i) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        row_d   = rotl_row(row_q);
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      row_q   <= ROW_FIRST;
    end else begin
      presc_q <= presc_d;
      row_q   <= row_d;
    end
  end

  assign row_o = row_q;

endmodule
`default_nettype wire

// File: rtl/matrix_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : matrix_frame_scheduler
// Summary  : Round-robin time-sharing of the two-frame 7x5 matrix selector
//            with dwell timing and row scan. Define MATRIX_BLANK_EN to insert
//            a BLANK_CYCLES blanking gap on every source switch.
// Revision : 1.0
// ============================================================================
module matrix_frame_scheduler
  import matrix_ctrl_pkg::*;
#(
  parameter int DWELL_CYCLES = 64,
  parameter int ROW_TICKS    = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ0,
  input  logic                REQ1,
  output logic                GNT0,
  output logic                GNT1,
  output logic                SEL,
  output logic                ENABLE,
  output logic [NUM_ROWS-1:0] ROW,
  output logic                FRAME_DONE
);

  if (DWELL_CYCLES < 2) begin : g_bad_dwell
    $error("DWELL_CYCLES must be at least 2");
  end
  if (ROW_TICKS < 1) begin : g_bad_row_ticks
    $error("ROW_TICKS must be at least 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("BLANK_CYCLES must be at least 1");
  end

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          sel_q, sel_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d, en_q, en_d;
  logic          row_restart, row_advance;
  logic          cur_src, own_req, oth_req, expire;

`ifdef MATRIX_BLANK_EN
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  logic [BW-1:0] blank_q, blank_d;
  logic          pend_q, pend_d;
`endif

  assign cur_src = (state_q == SHOW1);
  assign own_req = cur_src ? REQ1 : REQ0;
  assign oth_req = cur_src ? REQ0 : REQ1;
  assign expire  = (dwell_q == DWELL_LAST);

  always_comb begin
    state_d     = state_q;
    dwell_d     = '0;
    last_d      = last_q;
    done_d      = 1'b0;
    row_restart = 1'b0;
    row_advance = 1'b0;
`ifdef MATRIX_BLANK_EN
    blank_d     = blank_q;
    pend_d      = pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          // On a tie the source not served last wins.
          state_d     = (REQ1 && (!REQ0 || !last_q)) ? SHOW1 : SHOW0;
          row_restart = 1'b1;
        end
      end
      SHOW0, SHOW1: begin
        if (expire || !own_req) begin
          done_d = expire;
          last_d = cur_src;
          if (oth_req) begin
`ifdef MATRIX_BLANK_EN
            state_d = BLANK;
            pend_d  = ~cur_src;
            blank_d = '0;
`else
            state_d     = cur_src ? SHOW0 : SHOW1;
            row_restart = 1'b1;
`endif
          end else if (own_req) begin
            row_restart = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dwell_d     = dwell_q + 1'b1;
          row_advance = 1'b1;
        end
      end
`ifdef MATRIX_BLANK_EN
      BLANK: begin
        if (blank_q == BLANK_LAST) begin
          blank_d     = '0;
          state_d     = pend_q ? SHOW1 : SHOW0;
          row_restart = 1'b1;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it.
  assign gnt0_d = (state_d == SHOW0);
  assign gnt1_d = (state_d == SHOW1);
  assign en_d   = gnt0_d | gnt1_d;
  assign sel_d  = gnt1_d | (sel_q & ~gnt0_d);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      dwell_q <= '0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      en_q    <= 1'b0;
`ifdef MATRIX_BLANK_EN
      blank_q <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      last_q  <= last_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      en_q    <= en_d;
`ifdef MATRIX_BLANK_EN
      blank_q <= blank_d;
      pend_q  <= pend_d;
`endif
    end
  end

  row_scan_counter #(
    .ROW_TICKS (ROW_TICKS)
  ) u_row_scan (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .restart_i (row_restart),
    .advance_i (row_advance),
    .row_o     (ROW)
  );

  assign GNT0       = gnt0_q;
  assign GNT1       = gnt1_q;
  assign SEL        = sel_q;
  assign ENABLE     = en_q;
  assign FRAME_DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_frame_scheduler
// Summary  : Directed and random stimulus for matrix_frame_scheduler, checked
//            against a behavioural model (honours MATRIX_BLANK_EN).
// Revision : 1.0
// ============================================================================
module tb_matrix_frame_scheduler;

  localparam int D  = 8;
  localparam int BC = 2;
`ifdef MATRIX_BLANK_EN
  localparam int GAP = BC;
`else
  localparam int GAP = 0;
`endif

  logic       CLK = 1'b0;
  logic       RESET, REQ0, REQ1;
  logic       GNT0, GNT1, SEL, ENABLE, FRAME_DONE;
  logic [6:0] ROW;
  logic       GNT0_b, GNT1_b, SEL_b, ENABLE_b, FRAME_DONE_b;
  logic [6:0] ROW_b;
  bit         armed = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 CLK = ~CLK;

  matrix_frame_scheduler #(.DWELL_CYCLES(D), .ROW_TICKS(2), .BLANK_CYCLES(BC)) dut (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1), .GNT0(GNT0), .GNT1(GNT1),
    .SEL(SEL), .ENABLE(ENABLE), .ROW(ROW), .FRAME_DONE(FRAME_DONE));

  matrix_frame_scheduler #(.DWELL_CYCLES(D), .ROW_TICKS(1), .BLANK_CYCLES(BC)) dut_rt1 (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1), .GNT0(GNT0_b), .GNT1(GNT1_b),
    .SEL(SEL_b), .ENABLE(ENABLE_b), .ROW(ROW_b), .FRAME_DONE(FRAME_DONE_b));

  // mode: 0 idle, 1 showing src, 2 blanking toward pend; age = cycles since SHOW entry.
  typedef struct packed {
    int         mode;
    int         src;
    int         pend;
    int         age;
    int         left;
    int         last;
    logic       done;
    logic       sel;
    logic [6:0] row2;
    logic [6:0] row1;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t enter(input mdl_t s, input int src);
    mdl_t n;
    n      = s;
    n.mode = 1;
    n.src  = src;
    n.age  = 0;
    n.sel  = (src == 1);
    return n;
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic r0, input logic r1, input logic rst);
    mdl_t n;
    logic own, oth;
    logic [6:0] one;
    one    = 7'h01;
    n      = s;
    n.done = 1'b0;
    if (rst) begin
      n.mode = 0; n.src = 0; n.pend = 0; n.age = 0; n.left = 0; n.last = 1;
      n.sel = 1'b0; n.row2 = one; n.row1 = one;
    end else begin
      case (s.mode)
        0: if (r0 || r1) n = enter(n, (r0 && r1) ? 1 - s.last : (r0 ? 0 : 1));
        1: begin
          own = (s.src == 1) ? r1 : r0;
          oth = (s.src == 1) ? r0 : r1;
          if (s.age == D - 1 || !own) begin
            n.done = (s.age == D - 1);
            n.last = s.src;
            if (oth) begin
`ifdef MATRIX_BLANK_EN
              n.mode = 2; n.pend = 1 - s.src; n.left = BC;
`else
              n = enter(n, 1 - s.src);
`endif
            end else if (own) n = enter(n, s.src);
            else n.mode = 0;
          end else begin
            n.age = s.age + 1;
          end
        end
        default: begin
          n.left = s.left - 1;
          if (n.left == 0) n = enter(n, s.pend);
        end
      endcase
      if (n.mode == 1) begin
        n.row2 = one << ((n.age / 2) % 7);
        n.row1 = one << (n.age % 7);
      end
    end
    return n;
  endfunction

  always @(posedge CLK) m <= step(m, REQ0, REQ1, RESET);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      chk("gnt0",      GNT0,       (m.mode == 1 && m.src == 0));
      chk("gnt1",      GNT1,       (m.mode == 1 && m.src == 1));
      chk("enable",    ENABLE,     (m.mode == 1));
      chk("sel",       SEL,        m.sel);
      chk("frame_done", FRAME_DONE, m.done);
      chk("row",       ROW,        m.row2);
      chk("gnt_excl",  GNT0 & GNT1, 0);
      chk("row_onehot", $onehot(ROW), 1);
      chk("b_gnt",     {GNT0_b, GNT1_b}, {(m.mode == 1 && m.src == 0), (m.mode == 1 && m.src == 1)});
      chk("b_en_sel",  {ENABLE_b, SEL_b}, {(m.mode == 1), m.sel});
      chk("b_done",    FRAME_DONE_b, m.done);
      chk("b_row",     ROW_b,      m.row1);
      chk("b_row_onehot", $onehot(ROW_b), 1);
    end
  end

  task automatic do_reset();
    RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    int pulses;
    bit held;
    RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (2) @(negedge CLK);
    armed = 1'b1;
    chk("rst_row", ROW, 7'h01);
    chk("rst_en_gnt_sel_done", {ENABLE, GNT0, GNT1, SEL, FRAME_DONE}, 0);

    // Single requester: grant latency, row step, periodic FRAME_DONE.
    RESET = 1'b0; REQ0 = 1'b1;
    @(negedge CLK);
    chk("s1_gnt0", GNT0, 1); chk("s1_sel", SEL, 0); chk("s1_en", ENABLE, 1); chk("s1_row0", ROW, 7'h01);
    repeat (2) @(negedge CLK);
    chk("s1_row1", ROW, 7'h02);
    pulses = 0; held = 1'b1;
    repeat (23) begin
      @(negedge CLK);
      pulses += int'(FRAME_DONE);
      held &= GNT0;
    end
    chk("s1_done_count", pulses, 3);
    chk("s1_gnt0_held", held, 1);

    // Early release at dwell count 3, then tie goes to source 1.
    do_reset();
    REQ0 = 1'b1;
    repeat (4) @(negedge CLK);
    chk("s3_gnt0_age3", GNT0, 1);
    REQ0 = 1'b0;
    @(negedge CLK);
    chk("s3_idle", {ENABLE, GNT0, GNT1, FRAME_DONE}, 0);
    REQ0 = 1'b1; REQ1 = 1'b1;
    @(negedge CLK);
    chk("s3_tie_gnt1", {GNT0, GNT1, SEL}, 3'b011);

    // Reset at dwell count 5 in SHOW1.
    repeat (5) @(negedge CLK);
    chk("s4_gnt1_age5", GNT1, 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("s4_rst_outs", {ENABLE, GNT0, GNT1, SEL, FRAME_DONE}, 0);
    chk("s4_rst_row", ROW, 7'h01);
    RESET = 1'b0;
    @(negedge CLK);
    chk("s4_first_gnt0", {GNT0, GNT1}, 2'b10);

    // Both requesting: switch at expiry, with optional blanking gap.
    repeat (8) @(negedge CLK);
    chk("s2_done", FRAME_DONE, 1);
    if (GAP > 0) begin
      chk("s2_blank", {ENABLE, GNT0, GNT1, SEL}, 0);
      repeat (GAP) @(negedge CLK);
    end
    chk("s2_switch", {ENABLE, GNT0, GNT1, SEL}, 4'b1011);

    // REQ1 held, REQ0 pulsed mid-dwell: SHOW1 restarts.
    do_reset();
    REQ1 = 1'b1;
    repeat (3) @(negedge CLK);
    REQ0 = 1'b1;
    @(negedge CLK);
    REQ0 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("s5_row_rt1_row6", ROW_b, 7'h40);
    chk("s5_row_age6", ROW, 7'h08);
    @(negedge CLK);
    chk("s5_row_rt1_wrap", ROW_b, 7'h01);
    @(negedge CLK);
    chk("s5_restart", {GNT0, GNT1, FRAME_DONE}, 3'b011);
    chk("s5_restart_row", ROW, 7'h01);

    repeat (3) @(negedge CLK);
    REQ0 = 1'b1;
    repeat (5) @(negedge CLK);
    chk("s5_left_src1", GNT1, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 7) == 0) REQ0 = ~REQ0;
      if ($urandom_range(0, 7) == 0) REQ1 = ~REQ1;
      RESET = ($urandom_range(0, 299) == 0);
    end
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    armed = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
